// File: rtl/sorting_pkg.sv
// rtl/sorting_pkg.sv - shared sizes, record field positions and rank compare for sorting_top
// Record layout: {ID[11:0], F[7:0], S[11:0]}; ID is carried but never compared.
package sorting_pkg;

   localparam int DEPTH  = 16;
   localparam int DATA_W = 32;

   localparam int ID_MSB = 31;
   localparam int ID_LSB = 20;
   localparam int F_MSB  = 19;
   localparam int F_LSB  = 12;
   localparam int S_MSB  = 11;
   localparam int S_LSB  = 0;

   // a outranks b: higher F wins; on equal F the smaller S wins; full ties do not outrank
   function automatic logic outranks(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      logic [F_MSB-F_LSB:0] a_f;
      logic [F_MSB-F_LSB:0] b_f;
      logic [S_MSB-S_LSB:0] a_s;
      logic [S_MSB-S_LSB:0] b_s;
      a_f = a[F_MSB:F_LSB];
      b_f = b[F_MSB:F_LSB];
      a_s = a[S_MSB:S_LSB];
      b_s = b[S_MSB:S_LSB];
      return (a_f > b_f) || ((a_f == b_f) && (a_s < b_s));
   endfunction

endpackage

// File: rtl/sort_cell.sv
// rtl/sort_cell.sv - one slot of the insertion sorter chain
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   en, new_data     insertion enable and candidate record N
//   prev_data/valid  contents of the slot above (tied to 0 for slot 1)
//   prev_above       above() of the slot above (tied to 0 for slot 1)
//   data, valid      this slot's registered record and valid bit
//   above            this slot is empty or N outranks it
module sort_cell
   import sorting_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] new_data,
   input  logic [DATA_W-1:0] prev_data,
   input  logic              prev_valid,
   input  logic              prev_above,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              above
);

   logic insert;

   // a zero record is the null record and never enters the list
   assign insert = en && (new_data != '0);
   assign above  = !valid || outranks(new_data, data);

   // above() is monotonic down the chain, so the first slot with above set takes N
   // and every slot below it takes its upper neighbour (shift down)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (insert) begin
         if (prev_above) begin
            data  <= prev_data;
            valid <= prev_valid;
         end else if (above) begin
            data  <= new_data;
            valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/sorting_top.sv
// rtl/sorting_top.sv - streaming insertion sorter keeping the 16 best records by rank
// Ports:
//   clk                 clock, rising edge
//   rst                 asynchronous active-low reset, clears every slot
//   en                  insertion enable
//   input_data          record {ID, F, S}; 0 is a null record
//   sorted_data1..16    registered slot contents, slot 1 highest rank
module sorting_top
   import sorting_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] input_data,
   output logic [DATA_W-1:0] sorted_data1,
   output logic [DATA_W-1:0] sorted_data2,
   output logic [DATA_W-1:0] sorted_data3,
   output logic [DATA_W-1:0] sorted_data4,
   output logic [DATA_W-1:0] sorted_data5,
   output logic [DATA_W-1:0] sorted_data6,
   output logic [DATA_W-1:0] sorted_data7,
   output logic [DATA_W-1:0] sorted_data8,
   output logic [DATA_W-1:0] sorted_data9,
   output logic [DATA_W-1:0] sorted_data10,
   output logic [DATA_W-1:0] sorted_data11,
   output logic [DATA_W-1:0] sorted_data12,
   output logic [DATA_W-1:0] sorted_data13,
   output logic [DATA_W-1:0] sorted_data14,
   output logic [DATA_W-1:0] sorted_data15,
   output logic [DATA_W-1:0] sorted_data16
);

   logic [DATA_W-1:0] chain_data  [DEPTH];
   logic              chain_valid [DEPTH];
   logic              chain_above [DEPTH];

   // the last slot's above/valid feed nothing: a record pushed past slot 16 is discarded
   logic unused_tail;
   assign unused_tail = chain_above[DEPTH-1] | chain_valid[DEPTH-1];

   for (genvar i = 0; i < DEPTH; i++) begin : g_cell
      logic [DATA_W-1:0] p_data;
      logic              p_valid;
      logic              p_above;

      if (i == 0) begin : g_head
         assign p_data  = '0;
         assign p_valid = 1'b0;
         assign p_above = 1'b0;
      end else begin : g_link
         assign p_data  = chain_data[i-1];
         assign p_valid = chain_valid[i-1];
         assign p_above = chain_above[i-1];
      end

      sort_cell u_cell (
         .clk        (clk),
         .rst        (rst),
         .en         (en),
         .new_data   (input_data),
         .prev_data  (p_data),
         .prev_valid (p_valid),
         .prev_above (p_above),
         .data       (chain_data[i]),
         .valid      (chain_valid[i]),
         .above      (chain_above[i])
      );
   end

   assign sorted_data1  = chain_data[0];
   assign sorted_data2  = chain_data[1];
   assign sorted_data3  = chain_data[2];
   assign sorted_data4  = chain_data[3];
   assign sorted_data5  = chain_data[4];
   assign sorted_data6  = chain_data[5];
   assign sorted_data7  = chain_data[6];
   assign sorted_data8  = chain_data[7];
   assign sorted_data9  = chain_data[8];
   assign sorted_data10 = chain_data[9];
   assign sorted_data11 = chain_data[10];
   assign sorted_data12 = chain_data[11];
   assign sorted_data13 = chain_data[12];
   assign sorted_data14 = chain_data[13];
   assign sorted_data15 = chain_data[14];
   assign sorted_data16 = chain_data[15];

endmodule

// File: tb/tb_sorting_top.sv
// tb/tb_sorting_top.sv - self-checking bench for sorting_top
module tb_sorting_top;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [31:0] input_data = 32'h0;
   logic [31:0] sd [16];

   int compared = 0;
   int mismatched = 0;

   logic [31:0] model_q[$];

   typedef struct {
      string       name;
      logic        e;
      logic [31:0] d;
      logic [31:0] exp [16];
   } vec_t;

   vec_t tbl [10];

   sorting_top dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .input_data    (input_data),
      .sorted_data1  (sd[0]),
      .sorted_data2  (sd[1]),
      .sorted_data3  (sd[2]),
      .sorted_data4  (sd[3]),
      .sorted_data5  (sd[4]),
      .sorted_data6  (sd[5]),
      .sorted_data7  (sd[6]),
      .sorted_data8  (sd[7]),
      .sorted_data9  (sd[8]),
      .sorted_data10 (sd[9]),
      .sorted_data11 (sd[10]),
      .sorted_data12 (sd[11]),
      .sorted_data13 (sd[12]),
      .sorted_data14 (sd[13]),
      .sorted_data15 (sd[14]),
      .sorted_data16 (sd[15])
   );

   always #5 clk = ~clk;

   // single number per record: larger key means higher rank
   function automatic int rank_key(input logic [31:0] r);
      return int'(r[19:12]) * 4096 + (4095 - int'(r[11:0]));
   endfunction

   function automatic void model_insert(input logic [31:0] n);
      int pos;
      if (n == 32'h0) return;
      pos = model_q.size();
      for (int j = 0; j < model_q.size(); j++) begin
         if (rank_key(n) > rank_key(model_q[j])) begin
            pos = j;
            break;
         end
      end
      if (pos < 16) begin
         model_q.insert(pos, n);
         if (model_q.size() > 16) void'(model_q.pop_back());
      end
   endfunction

   function automatic logic [511:0] pack_model();
      logic [511:0] v;
      v = '0;
      for (int i = 0; i < 16; i++)
         if (i < model_q.size()) v[511-32*i -: 32] = model_q[i];
      return v;
   endfunction

   function automatic logic [511:0] pack_dut();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[511-32*i -: 32] = sd[i];
      return v;
   endfunction

   task automatic check(input string name, input logic [511:0] want);
      logic [511:0] got;
      got = pack_dut();
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
   endtask

   // inputs change on the falling edge; outputs sampled 1 time unit after the rising edge
   task automatic step(input logic e, input logic [31:0] d);
      @(negedge clk);
      en = e;
      input_data = d;
      @(posedge clk);
      #1;
      if (e) model_insert(d);
   endtask

   task automatic sync_reset_pulse();
      @(negedge clk);
      rst = 1'b0;
      en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [511:0] snap;

      tbl[0] = '{"ins1", 1'b1, 32'h00101001, '{0:32'h00101001, default:32'h0}};
      tbl[1] = '{"ins2", 1'b1, 32'h00201002, '{0:32'h00101001, 1:32'h00201002, default:32'h0}};
      tbl[2] = '{"ins3", 1'b1, 32'h00301005, '{0:32'h00101001, 1:32'h00201002, 2:32'h00301005, default:32'h0}};
      tbl[3] = '{"same_f_smaller_s", 1'b1, 32'h00401003, '{0:32'h00101001, 1:32'h00201002, 2:32'h00401003, 3:32'h00301005, default:32'h0}};
      tbl[4] = '{"same_f_larger_s", 1'b1, 32'h0050100D, '{0:32'h00101001, 1:32'h00201002, 2:32'h00401003, 3:32'h00301005, 4:32'h0050100D, default:32'h0}};
      tbl[5] = '{"larger_f_top", 1'b1, 32'h00604005, '{0:32'h00604005, 1:32'h00101001, 2:32'h00201002, 3:32'h00401003, 4:32'h00301005, 5:32'h0050100D, default:32'h0}};
      tbl[6] = '{"mid_f_slot2", 1'b1, 32'h0070302B, '{0:32'h00604005, 1:32'h0070302B, 2:32'h00101001, 3:32'h00201002, 4:32'h00401003, 5:32'h00301005, 6:32'h0050100D, default:32'h0}};
      tbl[7] = '{"en_low_hold", 1'b0, 32'h00801001, '{0:32'h00604005, 1:32'h0070302B, 2:32'h00101001, 3:32'h00201002, 4:32'h00401003, 5:32'h00301005, 6:32'h0050100D, default:32'h0}};
      tbl[8] = '{"equal_key_stable", 1'b1, 32'h00901001, '{0:32'h00604005, 1:32'h0070302B, 2:32'h00101001, 3:32'h00901001, 4:32'h00201002, 5:32'h00401003, 6:32'h00301005, 7:32'h0050100D, default:32'h0}};
      tbl[9] = '{"null_hold", 1'b1, 32'h00000000, '{0:32'h00604005, 1:32'h0070302B, 2:32'h00101001, 3:32'h00901001, 4:32'h00201002, 5:32'h00401003, 6:32'h00301005, 7:32'h0050100D, default:32'h0}};

      #1;
      check("reset_state", '0);
      #11;
      rst = 1'b1;

      for (int v = 0; v < 10; v++) begin
         logic [511:0] want;
         step(tbl[v].e, tbl[v].d);
         for (int i = 0; i < 16; i++) want[511-32*i -: 32] = tbl[v].exp[i];
         check(tbl[v].name, want);
      end

      // asynchronous reset between edges, list non-empty
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("async_reset_clear", '0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      model_q.delete();
      step(1'b1, 32'h00A02003);
      check("after_reset_slot1", {32'h00A02003, 480'h0});

      // overflow: 20 distinct records, then null cycles, then a record below slot 16
      sync_reset_pulse();
      for (int k = 0; k < 20; k++) begin
         d = {12'(k + 1), 8'($urandom_range(1, 255)), 12'($urandom_range(0, 4095))};
         step(1'b1, d);
         check($sformatf("overflow_%0d", k), pack_model());
      end
      snap = pack_model();
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 32'h0);
         check($sformatf("overflow_null_%0d", k), snap);
      end
      step(1'b1, {12'hABC, 8'h00, 12'hFFF});
      check("full_drop_low", snap);
      step(1'b0, 32'hFFF00000);
      check("full_en_low", snap);

      // random run with narrow key ranges so ties and equal keys are frequent
      sync_reset_pulse();
      for (int k = 0; k < 300; k++) begin
         logic e;
         e = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 4) == 0) d = 32'h0;
         else d = {12'($urandom_range(1, 4095)), 8'($urandom_range(0, 3)), 12'($urandom_range(0, 3))};
         step(e, d);
         check($sformatf("random_%0d", k), pack_model());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
